// File: rtl/tape_in_pkg.sv
// -----------------------------------------------------------------------------
// tape_in_pkg
// Shared types and default constants for the cassette input decoder.
//   - tape_state_e  : measurement FSM states (IDLE, ARMED, RUN, LOST)
//   - *_DEF         : default FILT_LEN / CNT_W / MIN_W values
//   - width_entry_t : one published half-period as stored by the optional
//                     width FIFO (TAPE_IN_WIDTH_FIFO_EN)
// -----------------------------------------------------------------------------
package tape_in_pkg;

  localparam int FILT_LEN_DEF = 4;   // consecutive ce samples to accept a level change
  localparam int CNT_W_DEF    = 12;  // half-period counter width
  localparam int MIN_W_DEF    = 3;   // shorter widths are treated as noise

  // Widest counter the FIFO entry can carry; narrower counters are zero-extended.
  localparam int CNT_W_MAX    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_LOST  = 2'd3
  } tape_state_e;

  typedef struct packed {
    logic                 ovf;
    logic                 lvl;
    logic [CNT_W_MAX-1:0] width;
  } width_entry_t;

endpackage

// File: rtl/tape_in_filter.sv
// -----------------------------------------------------------------------------
// tape_in_filter
// Two-flop synchroniser for the raw cassette input followed by a glitch
// filter that only accepts a level change after FILT_LEN consecutive
// differing samples taken on ce.
// Ports:
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   ce         in   sample strobe, one clk_sys cycle wide
//   tape_in    in   raw asynchronous cassette input
//   level      out  filtered level
//   edge_pulse out  one-cycle pulse, high in the cycle the new level appears
// -----------------------------------------------------------------------------
module tape_in_filter
  import tape_in_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ce,
  input  logic tape_in,
  output logic level,
  output logic edge_pulse
);

  logic       sync_a;
  logic       sync_b;
  logic [3:0] run_cnt;

  // Synchroniser runs every cycle; ce gating would only add latency.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync_b take the old sync_a,
      // which is exactly the two-stage shift we want.
      sync_a <= tape_in;
      sync_b <= sync_a;
    end
  end

  // run_cnt counts how many ce samples in a row disagreed with level; the
  // sample that finds it already at FILT_LEN-1 is the FILT_LEN-th one.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt    <= 4'd0;
      level      <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= 1'b0;
      if (ce) begin
        if (sync_b != level) begin
          if (run_cnt == 4'(FILT_LEN - 1)) begin
            level      <= ~level;
            run_cnt    <= 4'd0;
            edge_pulse <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 4'd1;
          end
        end else begin
          run_cnt <= 4'd0;
        end
      end
    end
  end

endmodule

// File: rtl/tape_in_decoder.sv
// -----------------------------------------------------------------------------
// tape_in_decoder
// Conditions the cassette input for the 177716 system register (bit 5) and,
// while the motor is on, measures half-period widths between accepted edges
// in ce ticks so a loader can classify bits.
// Ports:
//   clk_sys   in   system clock
//   reset_n   in   asynchronous active-low reset
//   ce        in   sample strobe (ce_12mp), one clk_sys cycle wide
//   tape_in   in   raw asynchronous cassette input
//   motor_on  in   motor enable level from the system register
//   tape_bit  out  filtered tape level
//   active    out  high while measuring (RUN)
//   width_stb out  publish pulse (FIFO build: FIFO non-empty)
//   width_o   out  measured half-period in ce ticks
//   width_lvl out  level held during the measured half-period
//   width_ovf out  published width was saturated
//   width_ack in   pops one FIFO entry (FIFO build only)
// Build option: define TAPE_IN_WIDTH_FIFO_EN to queue publishes in an
// 8-entry FIFO instead of a single overwrite register.
// -----------------------------------------------------------------------------
module tape_in_decoder
  import tape_in_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MIN_W    = MIN_W_DEF
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             tape_in,
  input  logic             motor_on,
  output logic             tape_bit,
  output logic             active,
  output logic             width_stb,
  output logic [CNT_W-1:0] width_o,
  output logic             width_lvl,
  output logic             width_ovf,
  input  logic             width_ack
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             lvl;
  logic             edge_pulse;

  tape_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             pub;
  logic [CNT_W-1:0] pub_width;
  logic             pub_ovf;

  tape_in_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ce         (ce),
    .tape_in    (tape_in),
    .level      (lvl),
    .edge_pulse (edge_pulse)
  );

  assign tape_bit = lvl;
  assign active   = (state == ST_RUN);

  // Priority inside each state: motor off, then edge, then ce. That makes a
  // motor drop beat a coincident edge, and an edge beat a coincident ce.
  always_comb begin
    // NOTE: defaults first, so no branch leaves an output unassigned and
    // no latch is inferred.
    state_nx  = state;
    cnt_nx    = cnt;
    pub       = 1'b0;
    pub_width = cnt;
    pub_ovf   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (motor_on) state_nx = ST_ARMED;
      end
      ST_ARMED: begin
        cnt_nx = '0;
        if (!motor_on)       state_nx = ST_IDLE;
        else if (edge_pulse) state_nx = ST_RUN;   // first edge only starts timing
      end
      ST_RUN: begin
        if (!motor_on) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (edge_pulse) begin
          pub    = (cnt >= CNT_W'(MIN_W));
          cnt_nx = '0;
        end else if (ce) begin
          cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          if (cnt_nx == CNT_MAX) state_nx = ST_LOST;
        end
      end
      ST_LOST: begin
        cnt_nx = CNT_MAX;
        if (!motor_on) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (edge_pulse) begin
          state_nx  = ST_RUN;
          cnt_nx    = '0;
          pub       = 1'b1;
          pub_width = CNT_MAX;
          pub_ovf   = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

`ifdef TAPE_IN_WIDTH_FIFO_EN

  width_entry_t mem [8];
  width_entry_t head;
  logic [2:0]   wr_ptr, rd_ptr;
  logic [3:0]   fill;
  logic         pop, do_push;
  logic         fifo_overflow;
  logic         motor_d;
  logic         unused_fifo;

  assign pop     = width_ack && (fill != 4'd0);
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = pub && ((fill != 4'd8) || pop);

  // NOTE: the storage array is deliberately left out of reset; fill gates
  // every read, so stale contents are never visible.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= '{ovf: pub_ovf, lvl: ~lvl, width: CNT_W_MAX'(pub_width)};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= 3'd0;
      rd_ptr        <= 3'd0;
      fill          <= 4'd0;
      fifo_overflow <= 1'b0;
      motor_d       <= 1'b0;
    end else begin
      motor_d <= motor_on;
      if (state == ST_IDLE) begin
        wr_ptr <= 3'd0;
        rd_ptr <= 3'd0;
        fill   <= 4'd0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 3'd1;
        if (pop)     rd_ptr <= rd_ptr + 3'd1;
        fill <= fill + {3'd0, do_push} - {3'd0, pop};
      end
      if (motor_d && !motor_on)  fifo_overflow <= 1'b0;
      else if (pub && !do_push)  fifo_overflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign width_stb = (fill != 4'd0);
  assign width_o   = width_stb ? head.width[CNT_W-1:0] : '0;
  assign width_lvl = width_stb & head.lvl;
  assign width_ovf = width_stb & head.ovf;

  // Overflow flag is kept for debug visibility only.
  assign unused_fifo = fifo_overflow;

`else

  logic unused_ack;
  assign unused_ack = width_ack;

  // The edge cycle already shows the new level, so the level that was held
  // during the finished half-period is its complement.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      width_stb <= 1'b0;
      width_o   <= '0;
      width_lvl <= 1'b0;
      width_ovf <= 1'b0;
    end else begin
      width_stb <= pub;
      if (pub) begin
        width_o   <= pub_width;
        width_lvl <= ~lvl;
        width_ovf <= pub_ovf;
      end
    end
  end

`endif

endmodule

// File: doc/tape_in_decoder.md
Name: tape_in_decoder

Overview:
- Upstream feeder for the system register read path at 177716.
- Conditions the raw cassette input `TAPE_IN`: 2-FF synchroniser, then a glitch filter clocked by a clock-enable.
- Drives the tape level bit (read-data bit 5 of 177716).
- Measures half-period widths between accepted edges, so a loader or turbo-tape helper can classify bits, gated by the motor-control bit written through the system register.

Parameters:
- FILT_LEN, 4: number of consecutive equal ce samples required before the filtered level changes (range 1..15).
- CNT_W, 12: width of the half-period counter; saturates at 2^CNT_W-1.
- MIN_W, 3: widths (in ce ticks) below this are discarded as noise and do not update width_o.

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- ce, in, 1: sample strobe, one clk_sys cycle wide (ce_12mp in the top level).
- tape_in, in, 1: raw asynchronous cassette input.
- motor_on, in, 1: motor enable, level; latched by the top level from a system register write.
- tape_bit, out, 1: filtered tape level, to sysreg read data bit 5.
- active, out, 1: high while in RUN.
- width_stb, out, 1: one-cycle pulse when a new width is published.
- width_o, out, CNT_W: measured half-period in ce ticks.
- width_lvl, out, 1: level that was held during the measured half-period.
- width_ovf, out, 1: published width was saturated.
- width_ack, in, 1: consumer acknowledge (used only with the FIFO option).

Behaviour:
- Reset (async, reset_n=0) values:
  - Sync flops 0; filter count 0; filtered level 0.
  - State IDLE; counter 0.
  - tape_bit=0, active=0, width_stb=0, width_o=0, width_lvl=0, width_ovf=0.
- Synchroniser: two flops on clk_sys every cycle; no ce gating.
- Filter:
  - Evaluated only on ce.
  - If synced input differs from filtered level, increment the run count; otherwise clear it.
  - When the run count reaches FILT_LEN-1 with the input still different: toggle the filtered level, clear the count, and raise an internal edge flag for exactly that clk_sys cycle.
  - tape_bit = filtered level, always, independent of motor_on.
  - Latency from a clean input step to tape_bit: 2 clk_sys cycles plus FILT_LEN ce ticks.
- FSM, all transitions on clk_sys:
  - IDLE: counter held at 0. motor_on=1 -> ARMED.
  - ARMED: counter held at 0. Edge -> RUN with counter=0; no width is published for this first edge. motor_on=0 -> IDLE.
  - RUN:
    - On each ce, counter += 1, saturating at all-ones.
    - On an edge:
      - If counter >= MIN_W, publish (width_o=counter, width_lvl=previous filtered level, width_ovf=0) and pulse width_stb the following cycle.
      - Counter resets to 0 regardless.
    - Counter reaches all-ones -> LOST.
    - motor_on=0 -> IDLE.
  - LOST:
    - active=0; counter holds at all-ones.
    - Edge -> RUN, publishing width_o = all-ones with width_ovf=1; counter restarts at 0.
    - motor_on=0 -> IDLE.
- Simultaneous events:
  - motor_on falling on the same cycle as an edge: IDLE wins and nothing is published.
  - Edge and ce on the same cycle: the edge wins and the counter loads 0, not 1.
- width_o, width_lvl and width_ovf hold their values until the next publish.
- Without FIFO: width_ack is ignored; a new publish overwrites the previous one.

Optional Feature:
- Macro: TAPE_IN_WIDTH_FIFO_EN.
- Defined:
  - Publishes go into an 8-entry FIFO of {ovf, lvl, width}.
  - width_o, width_lvl and width_ovf show the FIFO head; width_stb becomes a level meaning non-empty.
  - width_ack pops one entry when non-empty; an ack while empty is ignored.
  - Push while full drops the new entry and sets a sticky internal overflow flag, cleared by motor_on 1->0.
  - Push and pop on the same cycle while full: both happen.
  - IDLE flushes the FIFO.
- Undefined: the single-register behaviour above; no FIFO storage is synthesised.

Decomposition:
- Package tape_in_pkg holds:
  - State enum (IDLE, ARMED, RUN, LOST).
  - Default FILT_LEN, CNT_W and MIN_W constants.
  - FIFO entry struct typedef.
- One natural sub-module: tape_in_filter (synchroniser plus glitch filter, outputs level and edge pulse), instantiated once.

Test Plan:
- Reset release with tape_in=1, motor_on=0, FILT_LEN=4 -> tape_bit rises after 2 cycles + 4 ce; active=0; width_stb never pulses.
- motor_on=1, square wave of 40-tick half-periods -> first edge publishes nothing; each later edge gives width_stb with width_o=40 ±1, width_lvl alternating 1/0.
- Glitch of 3 ce ticks (< FILT_LEN) -> tape_bit unchanged; no edge. A 2-tick pulse passed through (FILT_LEN=1) -> width 2 < MIN_W, not published.
- No edge for 4095 ticks with CNT_W=12 -> LOST, active=0; the next edge publishes width_o=4095 with width_ovf=1, then normal widths resume.
- Motor dropped mid-half-period, on the same cycle as an edge -> IDLE, no publish; motor re-enabled -> ARMED; the first edge again publishes nothing.
- With TAPE_IN_WIDTH_FIFO_EN: 10 publishes with no ack -> the first 8 entries are retained and the overflow flag is set; 8 acks drain them in order, and width_stb then drops.
